// File: rtl/tron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tron_pkg
// Description : Shared types and constants for the light-cycle display path.
//               Grid geometry, trace grid and pixel typedefs, VGA timing
//               constants and the default colour set.
// Revision    : 1.0 - initial release
// ============================================================================
package tron_pkg;

    localparam int GRID_ROWS = 150;
    localparam int GRID_COLS = 200;

    typedef logic [GRID_ROWS-1:0][GRID_COLS-1:0] trace_grid_t;
    typedef logic [11:0]                         rgb_t;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_H_TOTAL   = 800;
    localparam int VGA_V_TOTAL   = 525;

    localparam rgb_t DEF_P1_RGB     = 12'h0F0;
    localparam rgb_t DEF_P2_RGB     = 12'hF0F;
    localparam rgb_t DEF_BOTH_RGB   = 12'hFFF;
    localparam rgb_t DEF_BORDER_RGB = 12'h00F;

endpackage
`default_nettype wire

// File: rtl/scaled_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : scaled_axis_counter
// Description : Tracks the grid cell index along one screen axis where each
//               cell spans SCALE screen units, without any division.
//               i_start forces the current position to cell 0 / sub 0;
//               i_advance moves one screen unit forward. o_cell / o_sub are
//               the indices of the *current* cycle (combinational view of
//               the update), the registers hold them for later cycles.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_start         - current unit is the first of the field
//               i_advance       - current unit is a later unit of the field
//               o_cell, o_sub   - cell index and sub-unit within the cell
// Revision    : 1.0 - initial release
// ============================================================================
module scaled_axis_counter #(
    parameter int SCALE  = 3,
    parameter int CELLS  = 200,
    parameter int CELL_W = 8,
    parameter int SUB_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_advance,
    output logic [CELL_W-1:0] o_cell,
    output logic [SUB_W-1:0]  o_sub
);

    localparam logic [SUB_W-1:0]  c_sub_last  = SUB_W'(SCALE - 1);
    localparam logic [CELL_W-1:0] c_cell_last = CELL_W'(CELLS - 1);

    logic [CELL_W-1:0] r_cell;
    logic [SUB_W-1:0]  r_sub;
    logic [CELL_W-1:0] w_cell;
    logic [SUB_W-1:0]  w_sub;

    always_comb begin
        w_cell = r_cell;
        w_sub  = r_sub;
        if (i_start) begin
            w_cell = '0;
            w_sub  = '0;
        end else if (i_advance) begin
            if (r_sub == c_sub_last) begin
                w_sub = '0;
                // The field is exactly CELLS*SCALE units long, so the clamp
                // never engages in normal scanning; it only keeps the index
                // in range if the enables are ever driven out of pattern.
                if (r_cell != c_cell_last) begin
                    w_cell = r_cell + CELL_W'(1);
                end
            end else begin
                w_sub = r_sub + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cell <= '0;
            r_sub  <= '0;
        end else begin
            r_cell <= w_cell;
            r_sub  <= w_sub;
        end
    end

    assign o_cell = w_cell;
    assign o_sub  = w_sub;

endmodule
`default_nettype wire

// File: rtl/trace_pixel_reader.sv
`default_nettype none
// ============================================================================
// Module      : trace_pixel_reader
// Description : Scans the two player trace grids in step with the VGA timing
//               counters and produces a registered 12-bit RGB stream
//               (2-cycle latency from row/col/blank to rgb). Also counts the
//               occupied cells of each grid once per frame and publishes the
//               totals with a one-cycle stats_valid pulse.
// Ports       : clock, reset          - pixel clock, sync active-high reset
//               p1_trace, p2_trace    - occupancy grids, indexed [r][c]
//               row, col, blank       - VGA timing position / blanking
//               rgb                   - {R,G,B} pixel colour, registered
//               p1_count, p2_count    - previous frame's occupied cell counts
//               stats_valid           - pulses when the counts update
// Revision    : 1.0 - initial release
// ============================================================================
module trace_pixel_reader
    import tron_pkg::*;
#(
    parameter int   SCALE      = 3,
    parameter int   OFF_X      = 20,
    parameter int   OFF_Y      = 15,
    parameter rgb_t P1_RGB     = DEF_P1_RGB,
    parameter rgb_t P2_RGB     = DEF_P2_RGB,
    parameter rgb_t BOTH_RGB   = DEF_BOTH_RGB,
    parameter rgb_t BORDER_RGB = DEF_BORDER_RGB
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [GRID_ROWS-1:0][GRID_COLS-1:0] p1_trace,
    input  logic [GRID_ROWS-1:0][GRID_COLS-1:0] p2_trace,
    input  logic [9:0]                          row,
    input  logic [9:0]                          col,
    input  logic                                blank,
    output logic [11:0]                         rgb,
    output logic [14:0]                         p1_count,
    output logic [14:0]                         p2_count,
    output logic                                stats_valid
);

    localparam int c_sub_w = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int c_row_w = $clog2(GRID_ROWS);
    localparam int c_col_w = $clog2(GRID_COLS);
    localparam int c_cnt_w = 15;

    localparam logic [9:0] c_x_lo   = 10'(OFF_X);
    localparam logic [9:0] c_x_hi   = 10'(OFF_X + GRID_COLS * SCALE);
    localparam logic [9:0] c_y_lo   = 10'(OFF_Y);
    localparam logic [9:0] c_y_hi   = 10'(OFF_Y + GRID_ROWS * SCALE);
    localparam logic [9:0] c_last_x = 10'(VGA_H_VISIBLE - 1);
    localparam logic [9:0] c_last_y = 10'(VGA_V_VISIBLE - 1);

    // ------------------------------------------------------------------
    // Stage 0: field decode and cell tracking
    // ------------------------------------------------------------------
    logic               w_col_in;
    logic               w_row_in;
    logic               w_in_field;
    logic               w_col_start;
    logic               w_col_adv;
    logic               w_row_start;
    logic               w_row_adv;
    logic               w_sample;
    logic               w_frame_end;
    logic [c_row_w-1:0] w_cell_r;
    logic [c_col_w-1:0] w_cell_c;
    logic [c_sub_w-1:0] w_sub_r;
    logic [c_sub_w-1:0] w_sub_c;

    assign w_col_in    = (col >= c_x_lo) && (col < c_x_hi);
    assign w_row_in    = (row >= c_y_lo) && (row < c_y_hi);
    assign w_in_field  = w_col_in && w_row_in;

    assign w_col_start = (col == c_x_lo);
    assign w_col_adv   = w_col_in && !w_col_start;

    // Row tracking steps once per line, on the col==0 cycle only.
    assign w_row_start = (col == 10'd0) && (row == c_y_lo);
    assign w_row_adv   = (col == 10'd0) && w_row_in && (row != c_y_lo);

    // The top-left screen pixel of each cell is the one cycle that counts it.
    assign w_sample    = w_in_field && (w_sub_r == '0) && (w_sub_c == '0);
    assign w_frame_end = (row == c_last_y) && (col == c_last_x);

    scaled_axis_counter #(
        .SCALE  (SCALE),
        .CELLS  (GRID_ROWS),
        .CELL_W (c_row_w),
        .SUB_W  (c_sub_w)
    ) u_row_counter (
        .clk       (clock),
        .rst       (reset),
        .i_start   (w_row_start),
        .i_advance (w_row_adv),
        .o_cell    (w_cell_r),
        .o_sub     (w_sub_r)
    );

    scaled_axis_counter #(
        .SCALE  (SCALE),
        .CELLS  (GRID_COLS),
        .CELL_W (c_col_w),
        .SUB_W  (c_sub_w)
    ) u_col_counter (
        .clk       (clock),
        .rst       (reset),
        .i_start   (w_col_start),
        .i_advance (w_col_adv),
        .o_cell    (w_cell_c),
        .o_sub     (w_sub_c)
    );

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic               r_s1_in_field;
    logic               r_s1_blank;
    logic [c_row_w-1:0] r_s1_cell_r;
    logic [c_col_w-1:0] r_s1_cell_c;
    logic               r_s1_sample;
    logic               r_s1_frame_end;

    // ------------------------------------------------------------------
    // Stage 2: grid read, colour select, accumulation
    // ------------------------------------------------------------------
    logic               w_p1_bit;
    logic               w_p2_bit;
    rgb_t               w_rgb;

    logic               r_s2_frame_end;
    rgb_t               r_rgb;
    logic [c_cnt_w-1:0] r_acc_p1;
    logic [c_cnt_w-1:0] r_acc_p2;
    logic [c_cnt_w-1:0] r_p1_count;
    logic [c_cnt_w-1:0] r_p2_count;
    logic               r_stats_valid;

    assign w_p1_bit = p1_trace[r_s1_cell_r][r_s1_cell_c];
    assign w_p2_bit = p2_trace[r_s1_cell_r][r_s1_cell_c];

    always_comb begin
        w_rgb = '0;
        if (r_s1_blank) begin
            w_rgb = '0;
        end else if (!r_s1_in_field) begin
            w_rgb = BORDER_RGB;
        end else begin
            case ({w_p1_bit, w_p2_bit})
                2'b11:   w_rgb = BOTH_RGB;
                2'b10:   w_rgb = P1_RGB;
                2'b01:   w_rgb = P2_RGB;
                default: w_rgb = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_in_field  <= 1'b0;
            r_s1_blank     <= 1'b0;
            r_s1_cell_r    <= '0;
            r_s1_cell_c    <= '0;
            r_s1_sample    <= 1'b0;
            r_s1_frame_end <= 1'b0;
            r_s2_frame_end <= 1'b0;
            r_rgb          <= '0;
            r_acc_p1       <= '0;
            r_acc_p2       <= '0;
            r_p1_count     <= '0;
            r_p2_count     <= '0;
            r_stats_valid  <= 1'b0;
        end else begin
            r_s1_in_field  <= w_in_field;
            r_s1_blank     <= blank;
            r_s1_cell_r    <= w_cell_r;
            r_s1_cell_c    <= w_cell_c;
            r_s1_sample    <= w_sample;
            r_s1_frame_end <= w_frame_end;

            r_s2_frame_end <= r_s1_frame_end;
            r_rgb          <= w_rgb;
            r_stats_valid  <= 1'b0;

            // The frame-end marker travels down the pipe so the copy happens
            // only after every in-flight sample has been accumulated.
            if (r_s2_frame_end) begin
                r_p1_count    <= r_acc_p1;
                r_p2_count    <= r_acc_p2;
                r_stats_valid <= 1'b1;
                r_acc_p1      <= '0;
                r_acc_p2      <= '0;
            end else if (r_s1_sample) begin
                r_acc_p1 <= r_acc_p1 + {{(c_cnt_w-1){1'b0}}, w_p1_bit};
                r_acc_p2 <= r_acc_p2 + {{(c_cnt_w-1){1'b0}}, w_p2_bit};
            end
        end
    end

    assign rgb         = r_rgb;
    assign p1_count    = r_p1_count;
    assign p2_count    = r_p2_count;
    assign stats_valid = r_stats_valid;

endmodule
`default_nettype wire
